load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory interface: accepts one load/store from the core datapath.
//  Issues word-aligned requests with byte enables to a word-wide, variable-latency data memory.
//  Splits misaligned accesses into two word transactions, then merges/sign-extends load data.
//  Sits between the execute stage and the data memory, replacing direct byte-addressed access.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width on both sides
//  DATA_WIDTH  32  data width; fixed at 32 (4 byte lanes)
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   reset, asynchronous, active-high
//  req_valid    in   1   core request present
//  req_ready    out  1   unit can accept a request (high only in IDLE)
//  req_write    in   1   1 = store, 0 = load
//  req_addr     in   ADDR_WIDTH  byte address, any alignment
//  req_wdata    in   DATA_WIDTH  store data, little-endian, low bytes used per size
//  load_store_type in 2  0=byte, 1=half, 2=word, 3=illegal
//  load_unsigned in  1   zero-extend (1) / sign-extend (0) load result
//  resp_valid   out  1   one-cycle pulse: transaction complete
//  resp_rdata   out  DATA_WIDTH  extended load data (0 for stores/errors)
//  resp_err     out  1   valid with resp_valid; set for load_store_type==3
//  mem_req      out  1   memory request, held until mem_gnt
//  mem_we       out  1   write strobe for current request
//  mem_addr     out  ADDR_WIDTH  word-aligned address (bits[1:0]=0)
//  mem_be       out  4   byte enables, bit i = byte lane i
//  mem_wdata    out  DATA_WIDTH  lane-aligned write data
//  mem_gnt      in   1   memory accepts request this cycle (mem_req && mem_gnt)
//  mem_rvalid   in   1   completion pulse for reads and writes, >=1 cycle after grant
//  mem_rdata    in   DATA_WIDTH  read word, valid with mem_rvalid
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1 after reset; resp_valid, resp_err, mem_req, mem_we=0; mem_be=0;
//    resp_rdata, mem_addr, mem_wdata=0; captured request and partial load data cleared.
//  - FSM: IDLE -> REQ0 -> WAIT0 -> [REQ1 -> WAIT1] -> RESP -> IDLE; illegal type: IDLE -> RESP.
//  - IDLE: req_valid&&req_ready captures all req_* fields; next state REQ0 (or RESP, err=1).
//  - REQx: mem_req=1 with stable addr/be/wdata/we; on mem_gnt -> WAITx; no limit on stall.
//  - WAITx: mem_req=0; on mem_rvalid capture mem_rdata; WAIT0 -> REQ1 if split, else RESP.
//  - RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err; then IDLE.
//  - Min latency, aligned, gnt immediate, rvalid 1 cycle later: accept T, mem_req T+1,
//    rvalid T+2, resp_valid T+3. Split access adds 2 cycles minimum.
//  - Lanes: o=addr[1:0], n=1/2/4 bytes; split iff o+n>4.
//    Word0: addr&~3, be=((1<<n)-1)<<o [3:0], wdata=req_wdata<<(8*o).
//    Word1: (addr&~3)+4 wrapping mod 2^ADDR_WIDTH, be=((1<<n)-1)>>(4-o),
//    wdata=req_wdata>>(8*(4-o)).
//  - Load merge: raw = ({rdata1,rdata0} >> 8*o) truncated to n bytes; extend per load_unsigned.
//  - Store response: resp_rdata=0, resp_err=0.
//  - mem_rvalid in IDLE/REQx/RESP ignored; mem_gnt outside REQx ignored.
//  - req_valid outside IDLE ignored (req_ready=0); core must hold request until accepted.
//  - rst mid-transaction: immediate return to reset values; no resp_valid for aborted request.
// TESTING
//  1 Aligned word load 0x100, mem word 0xDEADBEEF, gnt immediate -> one REQ be=1111,
//    resp_rdata=0xDEADBEEF at T+3.
//  2 Signed byte load 0x103, lane3=0x80 -> be=1000, resp_rdata=0xFFFFFF80;
//    unsigned -> 0x00000080.
//  3 Misaligned word store 0x102, data 0xAABBCCDD -> 0x100 be=1100 wdata=0xCCDD0000,
//    then 0x104 be=0011 wdata=0x0000AABB.
//  4 Half load 0x107, words 0x11xxxxxx/0xxxxxxx22, signed -> two reads, resp_rdata=0x00002211.
//  5 mem_gnt low 5 cycles in REQ0 -> mem_req, addr, be stable; resp follows after grant.
//    Type 3 -> no mem_req, resp_err=1 at T+1.
//  6 rst asserted in WAIT1 -> outputs at reset values; later rvalid ignored;
//    next request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Data-memory initiator. Issues word-aligned requests with byte
//            enables, splits misaligned accesses in two, merges load data.
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            load_store_type,
    input  logic                  load_unsigned,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] c_TYPE_BYTE    = 2'd0;
    localparam logic [1:0] c_TYPE_HALF    = 2'd1;
    localparam logic [1:0] c_TYPE_WORD    = 2'd2;
    localparam logic [1:0] c_TYPE_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_write;
    logic                    r_unsigned;
    logic                    r_err;
    logic [1:0]              r_type;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata0;
    logic [DATA_WIDTH-1:0]   r_rdata1;

    logic                    w_accept;
    logic                    w_split;
    logic [3:0]              w_mask;
    logic [7:0]              w_be_wide;
    logic [2*DATA_WIDTH-1:0] w_wdata_wide;
    logic [4:0]              w_shift;
    logic [ADDR_WIDTH-1:0]   w_addr0;
    logic [ADDR_WIDTH-1:0]   w_addr1;
    logic [DATA_WIDTH-1:0]   w_raw;
    logic [DATA_WIDTH-1:0]   w_load;

    assign w_accept = req_valid && (r_state == ST_IDLE);

    // Lane placement: shifting across a double-width vector yields both words at once.
    assign w_shift      = {r_addr[1:0], 3'b000};
    assign w_be_wide    = {4'b0000, w_mask} << r_addr[1:0];
    assign w_wdata_wide = {{DATA_WIDTH{1'b0}}, r_wdata} << w_shift;
    assign w_addr0      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_addr1      = w_addr0 + ADDR_WIDTH'(4);
    assign w_raw        = DATA_WIDTH'({r_rdata1, r_rdata0} >> w_shift);

    always_comb begin
        w_mask  = 4'b1111;
        w_split = 1'b0;
        case (r_type)
            c_TYPE_BYTE: w_mask = 4'b0001;
            c_TYPE_HALF: begin
                w_mask  = 4'b0011;
                w_split = (r_addr[1:0] == 2'd3);
            end
            c_TYPE_WORD: w_split = (r_addr[1:0] != 2'd0);
            default:     w_split = 1'b0;
        endcase
    end

    always_comb begin
        w_load = w_raw;
        case (r_type)
            c_TYPE_BYTE: w_load = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_raw[7:0]}
                                             : {{(DATA_WIDTH-8){w_raw[7]}}, w_raw[7:0]};
            c_TYPE_HALF: w_load = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_raw[15:0]}
                                             : {{(DATA_WIDTH-16){w_raw[15]}}, w_raw[15:0]};
            default:     w_load = w_raw;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (load_store_type == c_TYPE_ILLEGAL) ? ST_RESP : ST_REQ0;
                end
            end
            ST_REQ0:  if (mem_gnt)    w_state_nxt = ST_WAIT0;
            ST_WAIT0: if (mem_rvalid) w_state_nxt = w_split ? ST_REQ1 : ST_RESP;
            ST_REQ1:  if (mem_gnt)    w_state_nxt = ST_WAIT1;
            ST_WAIT1: if (mem_rvalid) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'b0000;
        mem_wdata  = '0;
        case (r_state)
            ST_REQ0: begin
                mem_req   = 1'b1;
                mem_we    = r_write;
                mem_addr  = w_addr0;
                mem_be    = w_be_wide[3:0];
                mem_wdata = w_wdata_wide[DATA_WIDTH-1:0];
            end
            ST_REQ1: begin
                mem_req   = 1'b1;
                mem_we    = r_write;
                mem_addr  = w_addr1;
                mem_be    = w_be_wide[7:4];
                mem_wdata = w_wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = (r_write || r_err) ? '0 : w_load;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_type     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            if (w_accept) begin
                r_write    <= req_write;
                r_unsigned <= load_unsigned;
                r_err      <= (load_store_type == c_TYPE_ILLEGAL);
                r_type     <= load_store_type;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_rdata0   <= '0;
                r_rdata1   <= '0;
            end
            if ((r_state == ST_WAIT0) && mem_rvalid) begin
                r_rdata0 <= mem_rdata;
            end
            if ((r_state == ST_WAIT1) && mem_rvalid) begin
                r_rdata1 <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit with a simple
//            variable-latency memory responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  load_store_type;
    logic        load_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .load_store_type(load_store_type), .load_unsigned(load_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    int          n_vec = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          gnt_delay = 0;
    int          rv_delay = 0;
    int          stall_cnt = 0;
    int          pend_cnt = -1;
    logic [31:0] pend_data = '0;
    int          log_n = 0;
    int          g_cnt = 0;
    int          resp_n = 0;
    int          resp_cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] resp_data = '0;
    logic        resp_err_s = 1'b0;
    logic [31:0] mem_words [128];
    logic [31:0] log_addr  [16];
    logic [3:0]  log_be    [16];
    logic [31:0] log_wdata [16];
    logic        log_we    [16];
    logic        log_gnt   [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder and response monitor, both mid-cycle.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (pend_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
                pend_cnt   = -1;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
            end
            mem_gnt = 1'b0;
            if (mem_req) begin
                log_addr[log_n]  = mem_addr;
                log_be[log_n]    = mem_be;
                log_wdata[log_n] = mem_wdata;
                log_we[log_n]    = mem_we;
                if (stall_cnt < gnt_delay) begin
                    stall_cnt++;
                    log_gnt[log_n] = 1'b0;
                end else begin
                    mem_gnt        = 1'b1;
                    stall_cnt      = 0;
                    g_cnt++;
                    log_gnt[log_n] = 1'b1;
                    pend_cnt       = rv_delay;
                    pend_data      = mem_we ? 32'h0 : mem_words[mem_addr[8:2]];
                end
                if (log_n < 15) log_n++;
            end
            if (resp_valid) begin
                resp_n++;
                resp_data  = resp_rdata;
                resp_err_s = resp_err;
                resp_cyc   = cyc;
            end
        end
    end

    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] ty, input logic uns);
        int k;
        int start;
        log_n = 0;
        g_cnt = 0;
        start = resp_n;
        @(negedge clk);
        req_valid       = 1'b1;
        req_write       = wr;
        req_addr        = addr;
        req_wdata       = wd;
        load_store_type = ty;
        load_unsigned   = uns;
        acc_cyc         = cyc;
        check_eq("req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (resp_n == start && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        check_eq("resp_pulse_count", resp_n - start, 1);
    endtask

    task automatic check_word(input string tag, input int idx, input logic [31:0] addr,
                              input logic [3:0] be, input logic we);
        check_eq({tag, "_addr"}, log_addr[idx], addr);
        check_eq({tag, "_be"}, log_be[idx], be);
        check_eq({tag, "_we"}, log_we[idx], we);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int start;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        load_store_type = 2'd0; load_unsigned = 1'b0;
        for (int i = 0; i < 128; i++) mem_words[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_err", resp_err, 0);
        check_eq("rst_resp_rdata", resp_rdata, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_be", mem_be, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_ready", req_ready, 1);

        // Aligned word load
        mem_words[64] = 32'hDEADBEEF;
        run_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        check_eq("t1_nreq", log_n, 1);
        check_word("t1_w0", 0, 32'h100, 4'b1111, 1'b0);
        check_eq("t1_rdata", resp_data, 32'hDEADBEEF);
        check_eq("t1_err", resp_err_s, 0);
        check_eq("t1_latency", resp_cyc - acc_cyc, 3);

        // Byte loads from lane 3, signed then unsigned
        mem_words[64] = 32'h80123456;
        run_req(1'b0, 32'h103, 32'h0, 2'd0, 1'b0);
        check_word("t2s_w0", 0, 32'h100, 4'b1000, 1'b0);
        check_eq("t2s_rdata", resp_data, 32'hFFFFFF80);
        run_req(1'b0, 32'h103, 32'h0, 2'd0, 1'b1);
        check_eq("t2u_rdata", resp_data, 32'h00000080);

        // Signed half load, aligned within the word
        mem_words[64] = 32'h9ABC1234;
        run_req(1'b0, 32'h102, 32'h0, 2'd1, 1'b0);
        check_word("t2h_w0", 0, 32'h100, 4'b1100, 1'b0);
        check_eq("t2h_rdata", resp_data, 32'hFFFF9ABC);

        // Misaligned word store split over two words
        run_req(1'b1, 32'h102, 32'hAABBCCDD, 2'd2, 1'b0);
        check_eq("t3_nreq", log_n, 2);
        check_word("t3_w0", 0, 32'h100, 4'b1100, 1'b1);
        check_eq("t3_w0_wdata", log_wdata[0], 32'hCCDD0000);
        check_word("t3_w1", 1, 32'h104, 4'b0011, 1'b1);
        check_eq("t3_w1_wdata", log_wdata[1], 32'h0000AABB);
        check_eq("t3_rdata", resp_data, 32'h0);
        check_eq("t3_latency", resp_cyc - acc_cyc, 5);

        // Byte store into lane 1
        run_req(1'b1, 32'h101, 32'h12345678, 2'd0, 1'b0);
        check_eq("t3b_nreq", log_n, 1);
        check_word("t3b_w0", 0, 32'h100, 4'b0010, 1'b1);
        check_eq("t3b_wdata", log_wdata[0], 32'h34567800);

        // Half load straddling 0x104/0x108
        mem_words[65] = 32'h11AABBCC;
        mem_words[66] = 32'h33445522;
        run_req(1'b0, 32'h107, 32'h0, 2'd1, 1'b0);
        check_eq("t4_nreq", log_n, 2);
        check_word("t4_w0", 0, 32'h104, 4'b1000, 1'b0);
        check_word("t4_w1", 1, 32'h108, 4'b0001, 1'b0);
        check_eq("t4_rdata", resp_data, 32'h00002211);

        // Word load wrapping past the top of the address space
        mem_words[127] = 32'h55667788;
        mem_words[0]   = 32'h11223344;
        run_req(1'b0, 32'hFFFFFFFE, 32'h0, 2'd2, 1'b0);
        check_word("wrap_w0", 0, 32'hFFFFFFFC, 4'b1100, 1'b0);
        check_word("wrap_w1", 1, 32'h00000000, 4'b0011, 1'b0);
        check_eq("wrap_rdata", resp_data, 32'h33445566);

        // Grant withheld for 5 cycles
        mem_words[64] = 32'hDEADBEEF;
        gnt_delay = 5;
        run_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        gnt_delay = 0;
        check_eq("t5_req_samples", log_n, 6);
        for (int i = 0; i < 6; i++) begin
            check_word("t5_stall", i, 32'h100, 4'b1111, 1'b0);
        end
        check_eq("t5_last_gnt", log_gnt[5], 1);
        check_eq("t5_rdata", resp_data, 32'hDEADBEEF);
        check_eq("t5_latency", resp_cyc - acc_cyc, 8);

        // Illegal type: no memory traffic, error next cycle
        run_req(1'b0, 32'h100, 32'h0, 2'd3, 1'b0);
        check_eq("t5e_nreq", log_n, 0);
        check_eq("t5e_err", resp_err_s, 1);
        check_eq("t5e_rdata", resp_data, 32'h0);
        check_eq("t5e_latency", resp_cyc - acc_cyc, 1);

        // Reset while waiting on the second word
        rv_delay = 3;
        log_n = 0;
        g_cnt = 0;
        start = resp_n;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h107;
        load_store_type = 2'd1; load_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (g_cnt < 2 && k < 50) begin
            @(posedge clk);
            k++;
        end
        check_eq("t6_grants", g_cnt, 2);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_ready", req_ready, 1);
        check_eq("t6_mem_req", mem_req, 0);
        check_eq("t6_mem_be", mem_be, 0);
        check_eq("t6_mem_addr", mem_addr, 0);
        check_eq("t6_resp_valid", resp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        rv_delay = 0;
        repeat (8) @(posedge clk);
        check_eq("t6_no_resp", resp_n - start, 0);
        run_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b1);
        check_eq("t6_next_rdata", resp_data, 32'hDEADBEEF);
        check_eq("t6_next_latency", resp_cyc - acc_cyc, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
